// File: rtl/lfsr_seg_stepper.sv
// 8-bit Galois LFSR core with seed load, prescaled free-run and single-step,
// presenting one state nibble as a registered 7-segment digit.
module lfsr_seg_stepper #(
  parameter logic [7:0]  TAPS      = 8'hB8,
  parameter int unsigned PRESC_MAX = 9_999_999,
  parameter int unsigned PRESC_W   = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] seed,
  input  logic       load,
  input  logic       run,
  input  logic       step,
  input  logic       nib_sel,
  output logic [7:0] state,
  output logic [6:0] segments,
  output logic       dp,
  output logic       cycled
);

  localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(PRESC_MAX);

  function automatic logic [7:0] lfsr_adv(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Pin inputs packed as {step, run, load}
  logic [2:0]         sync_s1, sync_s2, sync_s2_d;
  logic [7:0]         ref_seed;
  logic [PRESC_W-1:0] presc;

  logic       load_edge, step_edge, run_s, tick, adv;
  logic [7:0] nxt, seed_eff;

  // Synchronisers and edge history run regardless of ena, so edges seen
  // while disabled are consumed rather than deferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s1   <= '0;
      sync_s2   <= '0;
      sync_s2_d <= '0;
    end else begin
      sync_s1   <= {step, run, load};
      sync_s2   <= sync_s1;
      sync_s2_d <= sync_s2;
    end
  end

  assign load_edge = sync_s2[0] & ~sync_s2_d[0];
  assign step_edge = sync_s2[2] & ~sync_s2_d[2];
  assign run_s     = sync_s2[1];
  assign tick      = run_s && (presc == PRESC_TOP);
  assign adv       = !load_edge && ((step_edge && !run_s) || tick);
  assign nxt       = lfsr_adv(state);
  assign seed_eff  = (seed == 8'h00) ? 8'h01 : seed;

  // State update stage; segments decode the registered state one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= 8'h01;
      ref_seed <= 8'h01;
      presc    <= '0;
      dp       <= 1'b0;
      cycled   <= 1'b0;
      segments <= 7'h06;
    end else if (ena) begin
      if (load_edge) begin
        state    <= seed_eff;
        ref_seed <= seed_eff;
        presc    <= '0;
        cycled   <= 1'b0;
      end else begin
        if (!run_s || tick)
          presc <= '0;
        else
          presc <= presc + PRESC_W'(1);
        if (adv) begin
          state <= nxt;
          dp    <= ~dp;
          if (nxt == ref_seed)
            cycled <= 1'b1;
        end
      end
      segments <= hex7(nib_sel ? state[7:4] : state[3:0]);
    end
  end

endmodule

// File: tb/tb_lfsr_seg_stepper.sv
// Scoreboarded directed bench: stimulus schedules expected values per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_lfsr_seg_stepper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] seed;
  logic       load, run, step, nib_sel;
  logic [7:0] state;
  logic [6:0] segments;
  logic       dp, cycled;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  // m: [3]=state [2]=segments [1]=dp [0]=cycled
  typedef struct {
    int         at;
    string      nm;
    logic [3:0] m;
    logic [7:0] st;
    logic [6:0] sg;
    logic       d;
    logic       cy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  lfsr_seg_stepper #(.TAPS(8'hB8), .PRESC_MAX(3), .PRESC_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .seed(seed), .load(load),
    .run(run), .step(step), .nib_sel(nib_sel), .state(state),
    .segments(segments), .dp(dp), .cycled(cycled)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic exp_push(input int at, input string nm, input logic [3:0] m,
                          input logic [7:0] st, input logic [6:0] sg,
                          input logic d, input logic cy);
    exp_t e;
    int i;
    e.at = at; e.nm = nm; e.m = m; e.st = st; e.sg = sg; e.d = d; e.cy = cy;
    i = 0;
    while (i < exp_q.size() && exp_q[i].at <= at) i++;
    exp_q.insert(i, e);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.at < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s: check for cyc %0d missed, now %0d", mon_e.nm, mon_e.at, cyc);
      end else begin
        if (mon_e.m[3]) chk({mon_e.nm, "_state"}, state, mon_e.st);
        if (mon_e.m[2]) chk({mon_e.nm, "_seg"}, {1'b0, segments}, {1'b0, mon_e.sg});
        if (mon_e.m[1]) chk({mon_e.nm, "_dp"}, {7'd0, dp}, {7'd0, mon_e.d});
        if (mon_e.m[0]) chk({mon_e.nm, "_cycled"}, {7'd0, cycled}, {7'd0, mon_e.cy});
      end
    end
  end

  task automatic step_pulse(input logic [7:0] prev, input logic [7:0] st,
                            input logic [6:0] sg, input logic d);
    int c;
    c = cyc;
    exp_push(c + 2, "step_pre", 4'b1000, prev, 7'h00, 1'b0, 1'b0);
    exp_push(c + 3, "step", 4'b1011, st, 7'h00, d, 1'b0);
    exp_push(c + 4, "step", 4'b0100, 8'h00, sg, 1'b0, 1'b0);
    step = 1'b1;
    tick(2);
    step = 1'b0;
    tick(4);
  endtask

  task automatic load_pulse(input logic [7:0] sv, input logic [7:0] prev,
                            input logic [7:0] st, input logic [6:0] sg,
                            input logic d);
    int c;
    c = cyc;
    exp_push(c + 2, "load_pre", 4'b1000, prev, 7'h00, 1'b0, 1'b0);
    exp_push(c + 3, "load", 4'b1011, st, 7'h00, d, 1'b0);
    exp_push(c + 4, "load", 4'b0100, 8'h00, sg, 1'b0, 1'b0);
    seed = sv;
    load = 1'b1;
    tick(2);
    load = 1'b0;
    tick(4);
  endtask

  initial begin
    int c;
    int e;
    int w;
    rst_n = 1'b0; ena = 1'b1; seed = 8'h00;
    load = 1'b0; run = 1'b0; step = 1'b0; nib_sel = 1'b0;
    tick(3);
    rst_n = 1'b1;
    c = cyc;
    for (int k = 0; k < 10; k++)
      exp_push(c + k, "reset", 4'b1111, 8'h01, 7'h06, 1'b0, 1'b0);
    tick(10);

    step_pulse(8'h01, 8'hB8, 7'h7F, 1'b1);
    step_pulse(8'hB8, 8'h5C, 7'h39, 1'b0);
    step_pulse(8'h5C, 8'h2E, 7'h79, 1'b1);

    load_pulse(8'hB5, 8'h2E, 8'hB5, 7'h6D, 1'b1);
    c = cyc;
    nib_sel = 1'b1;
    exp_push(c + 1, "nib_hi", 4'b0100, 8'h00, 7'h7C, 1'b0, 1'b0);
    tick(3);
    c = cyc;
    nib_sel = 1'b0;
    exp_push(c + 1, "nib_lo", 4'b0100, 8'h00, 7'h6D, 1'b0, 1'b0);
    tick(3);

    load_pulse(8'h00, 8'hB5, 8'h01, 7'h06, 1'b1);

    // Free run: advance n lands at c+2+4n
    c = cyc;
    run = 1'b1;
    exp_push(c + 5,    "run_pre",  4'b1011, 8'h01, 7'h00, 1'b1, 1'b0);
    exp_push(c + 6,    "run_adv1", 4'b1011, 8'hB8, 7'h00, 1'b0, 1'b0);
    exp_push(c + 7,    "run_adv1", 4'b0100, 8'h00, 7'h7F, 1'b0, 1'b0);
    exp_push(c + 1018, "run_a254", 4'b1001, 8'h02, 7'h00, 1'b0, 1'b0);
    exp_push(c + 1019, "run_a254", 4'b0100, 8'h00, 7'h5B, 1'b0, 1'b0);
    exp_push(c + 1022, "run_a255", 4'b1011, 8'h01, 7'h00, 1'b0, 1'b1);
    exp_push(c + 1023, "run_a255", 4'b0100, 8'h00, 7'h06, 1'b0, 1'b0);
    wait_until(c + 1023);

    ena = 1'b0;
    exp_push(c + 1026, "ena_frz", 4'b1011, 8'h01, 7'h00, 1'b0, 1'b1);
    exp_push(c + 1043, "ena_frz", 4'b1000, 8'h01, 7'h00, 1'b0, 1'b0);
    wait_until(c + 1043);
    ena = 1'b1;
    exp_push(c + 1045, "ena_res", 4'b1000, 8'h01, 7'h00, 1'b0, 1'b0);
    exp_push(c + 1046, "ena_res", 4'b1011, 8'hB8, 7'h00, 1'b1, 1'b1);

    wait_until(c + 1048);
    step = 1'b1;
    exp_push(c + 1051, "step_run", 4'b1010, 8'h5C, 7'h00, 1'b0, 1'b0);
    exp_push(c + 1053, "step_run", 4'b1000, 8'h5C, 7'h00, 1'b0, 1'b0);
    exp_push(c + 1054, "step_run", 4'b1010, 8'h2E, 7'h00, 1'b1, 1'b0);
    wait_until(c + 1050);
    step = 1'b0;

    wait_until(c + 1055);
    seed = 8'h3C;
    load = 1'b1;
    exp_push(c + 1057, "ld_tick", 4'b1000, 8'h2E, 7'h00, 1'b0, 1'b0);
    exp_push(c + 1058, "ld_tick", 4'b1011, 8'h3C, 7'h00, 1'b1, 1'b0);
    exp_push(c + 1059, "ld_tick", 4'b0100, 8'h00, 7'h39, 1'b0, 1'b0);
    exp_push(c + 1061, "ld_presc", 4'b1000, 8'h3C, 7'h00, 1'b0, 1'b0);
    exp_push(c + 1062, "ld_presc", 4'b1011, 8'h1E, 7'h00, 1'b0, 1'b0);
    exp_push(c + 1063, "ld_presc", 4'b0100, 8'h00, 7'h79, 1'b0, 1'b0);
    wait_until(c + 1057);
    load = 1'b0;
    wait_until(c + 1064);

    // Asynchronous reset while running
    e = cyc;
    run = 1'b0;
    rst_n = 1'b0;
    exp_push(e, "rst_mid", 4'b1111, 8'h01, 7'h06, 1'b0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    e = cyc;
    for (int k = 0; k < 3; k++)
      exp_push(e + k, "rst_rel", 4'b1111, 8'h01, 7'h06, 1'b0, 1'b0);
    tick(4);

    w = 0;
    while (exp_q.size() > 0 && w < 50) begin
      tick(1);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d checks pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
